// File: rtl/pc_next_gen_if.sv
// Instruction-cache request channel between the fetch PC generator and the I-cache.
// The PC generator is the master (drives request and address); the cache is the slave (drives ready).
interface pc_next_gen_if #(
  parameter int PC_WIDTH = 32
);
  logic                icache_re;
  logic [PC_WIDTH-1:0] icache_addr;
  logic                icache_ready;

  modport master (
    output icache_re,
    output icache_addr,
    input  icache_ready
  );

  modport slave (
    input  icache_re,
    input  icache_addr,
    output icache_ready
  );
endinterface

// File: rtl/pc_next_gen.sv
// Fetch PC generator: owns the architectural fetch PC, issues I-cache reads and
// resolves branch redirect / decode jump / sequential next-PC with one-cycle delivery tracking.
module pc_next_gen #(
  parameter int                   PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = 32'h4000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          pc_add_select,
  input  logic                dec_valid,
  input  logic [PC_WIDTH-1:0] dec_pc,
  input  logic [PC_WIDTH-1:0] dec_imm,
  input  logic [PC_WIDTH-1:0] dec_rs1,
  input  logic                br_redirect,
  input  logic [PC_WIDTH-1:0] br_target,
  input  logic                stall,
  pc_next_gen_if.master       icache,
  output logic [PC_WIDTH-1:0] fetch_pc,
  output logic                fetch_valid,
  output logic                kill
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [PC_WIDTH-1:0] PC_STEP = {{(PC_WIDTH-3){1'b0}}, 3'b100};

  // JALR target: rs1 + imm with bit 0 forced low.
  function automatic logic [PC_WIDTH-1:0] jalr_target(input logic [PC_WIDTH-1:0] base,
                                                      input logic [PC_WIDTH-1:0] offset);
    logic [PC_WIDTH-1:0] sum;
    sum    = base + offset;
    sum[0] = 1'b0;
    return sum;
  endfunction

  state_t              state_r;
  state_t              state_next_s;
  logic [PC_WIDTH-1:0] pc_r;
  logic                pending_valid_r;
  logic [PC_WIDTH-1:0] pending_target_r;
  logic [PC_WIDTH-1:0] fetch_pc_r;
  logic                fetch_valid_r;
  logic                kill_r;

  logic                jal_s;
  logic                jalr_s;
  logic                taken_s;
  logic                redirect_hit_s;
  logic [PC_WIDTH-1:0] next_pc_s;
  logic                issue_s;
  logic                accept_s;

  // Next-PC priority resolution and request handshake qualification.
  always_comb begin
    jal_s          = dec_valid && (pc_add_select == 2'b01);
    jalr_s         = dec_valid && (pc_add_select == 2'b11);
    taken_s        = br_redirect || jal_s || jalr_s;
    redirect_hit_s = taken_s || pending_valid_r;
    if (br_redirect) begin
      next_pc_s = br_target;
    end else if (pending_valid_r) begin
      next_pc_s = pending_target_r;
    end else if (jal_s) begin
      next_pc_s = dec_pc + dec_imm;
    end else if (jalr_s) begin
      next_pc_s = jalr_target(dec_rs1, dec_imm);
    end else begin
      next_pc_s = pc_r + PC_STEP;
    end
    issue_s  = rst && (state_r != ST_HOLD) && !stall;
    accept_s = issue_s && icache.icache_ready;
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_BOOT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_BOOT: state_next_s = accept_s ? ST_RUN : ST_BOOT;
      ST_RUN:  state_next_s = (stall || !icache.icache_ready) ? ST_HOLD : ST_RUN;
      ST_HOLD: state_next_s = stall ? ST_HOLD : ST_RUN;
      default: state_next_s = ST_BOOT;
    endcase
  end

  // Request outputs.
  always_comb begin
    icache.icache_re   = 1'b0;
    icache.icache_addr = pc_r;
    case (state_r)
      ST_BOOT: icache.icache_re = issue_s;
      ST_RUN:  icache.icache_re = issue_s;
      ST_HOLD: icache.icache_re = 1'b0;
      default: icache.icache_re = 1'b0;
    endcase
  end

  // PC, pending redirect and delivery tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r             <= RESET_PC;
      pending_valid_r  <= 1'b0;
      pending_target_r <= {PC_WIDTH{1'b0}};
      fetch_pc_r       <= {PC_WIDTH{1'b0}};
      fetch_valid_r    <= 1'b0;
      kill_r           <= 1'b0;
    end else begin
      kill_r <= br_redirect;
      if (accept_s) begin
        pc_r            <= next_pc_s;
        pending_valid_r <= 1'b0;
        fetch_pc_r      <= pc_r;
        fetch_valid_r   <= !taken_s;
      end else begin
        // A redirect that cannot issue now is parked until the next issuing cycle.
        if (state_next_s == ST_HOLD) begin
          pending_valid_r  <= redirect_hit_s;
          pending_target_r <= next_pc_s;
        end else begin
          pc_r            <= redirect_hit_s ? next_pc_s : pc_r;
          pending_valid_r <= 1'b0;
        end
        if (!stall) begin
          fetch_valid_r <= 1'b0;
        end
      end
    end
  end

  assign fetch_pc    = fetch_pc_r;
  assign fetch_valid = fetch_valid_r;
  assign kill        = kill_r;

endmodule
